// File: rtl/hwrandom_stream.sv
// Entropy pipeline: raw ring-oscillator bits are synchronised, XOR-folded,
// health-tested, optionally von Neumann debiased, packed into bytes, buffered
// in a FIFO and streamed out over 8N1 UART.
// Optional feature macro: HWRANDOM_VON_NEUMANN_EN (von Neumann debiaser).
module hwrandom_stream #(
    parameter int unsigned NUM_CHANNELS       = 4,
    parameter int unsigned SAMPLE_DIV         = 8,
    parameter int unsigned FIFO_DEPTH         = 16,
    parameter int unsigned REP_LIMIT          = 32,
    parameter int unsigned comm_clk_frequency = 50_000_000,
    parameter int unsigned baud_rate          = 115200
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_CHANNELS-1:0]           raw_bits,
    output logic                              TxD,
    output logic [31:0]                       disp_word,
    output logic                              health_fail,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level,
    output logic [15:0]                       overflow_count
);

    localparam int unsigned BIT_CYCLES = comm_clk_frequency / baud_rate;
    localparam int unsigned DIV_W      = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int unsigned REP_W      = $clog2(REP_LIMIT + 1);
    localparam int unsigned PTR_W      = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W      = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned BAUD_W     = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StStart = 2'd1;
    localparam logic [1:0] StData  = 2'd2;
    localparam logic [1:0] StStop  = 2'd3;

    // Two-flop synchroniser; left unreset so it keeps tracking the oscillators
    // through reset and the first post-reset sample is already meaningful.
    logic [NUM_CHANNELS-1:0] sync1_q, sync2_q;
    always_ff @(posedge clk) begin
        sync1_q <= raw_bits;
        sync2_q <= sync1_q;
    end

    logic s;
    assign s = ^sync2_q;

    // Sample strobe divider.
    logic [DIV_W-1:0] div_q;
    logic             strobe;
    assign strobe = (div_q == DIV_W'(SAMPLE_DIV - 1));

    always_ff @(posedge clk) begin
        if (reset)       div_q <= '0;
        else if (strobe) div_q <= '0;
        else             div_q <= div_q + 1'b1;
    end

    // Repetition-count health test next-state.
    logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
    logic             seen_q, seen_d, last_q, last_d;
    logic             fail_q, fail_d, trip, sample_ok;

    always_comb begin
        rep_cnt_d = rep_cnt_q;
        seen_d    = seen_q;
        last_d    = last_q;
        fail_d    = fail_q;
        trip      = 1'b0;
        if (strobe) begin
            seen_d = 1'b1;
            last_d = s;
            if (!seen_q || (s != last_q))                rep_cnt_d = REP_W'(1);
            else if (rep_cnt_q != REP_W'(REP_LIMIT))     rep_cnt_d = rep_cnt_q + 1'b1;
            if (rep_cnt_d == REP_W'(REP_LIMIT)) begin
                trip   = 1'b1;
                fail_d = 1'b1;
            end
        end
    end

    // The tripping sample itself is discarded as well.
    assign sample_ok = strobe && !fail_q && !trip;

    // Health-test state.
    always_ff @(posedge clk) begin
        if (reset) begin
            rep_cnt_q <= '0;
            seen_q    <= 1'b0;
            last_q    <= 1'b0;
            fail_q    <= 1'b0;
        end else begin
            rep_cnt_q <= rep_cnt_d;
            seen_q    <= seen_d;
            last_q    <= last_d;
            fail_q    <= fail_d;
        end
    end

    logic bit_valid, bit_val;

`ifdef HWRANDOM_VON_NEUMANN_EN
    logic vn_have_q, vn_first_q;

    // Pair register: hold the first sample, release it on the second.
    always_ff @(posedge clk) begin
        if (reset) begin
            vn_have_q  <= 1'b0;
            vn_first_q <= 1'b0;
        end else if (sample_ok) begin
            if (!vn_have_q) begin
                vn_have_q  <= 1'b1;
                vn_first_q <= s;
            end else begin
                vn_have_q  <= 1'b0;
            end
        end
    end

    // 10 -> 1, 01 -> 0: the emitted bit equals the first sample of the pair.
    assign bit_valid = sample_ok && vn_have_q && (vn_first_q != s);
    assign bit_val   = vn_first_q;
`else
    assign bit_valid = sample_ok;
    assign bit_val   = s;
`endif

    // Byte assembly, MSB first.
    logic [6:0]  sh_q;
    logic [2:0]  bitcnt_q;
    logic [31:0] disp_q;
    logic        byte_done;
    logic [7:0]  new_byte;

    assign byte_done = bit_valid && (bitcnt_q == 3'd7);
    assign new_byte  = {sh_q, bit_val};

    always_ff @(posedge clk) begin
        if (reset) begin
            sh_q     <= '0;
            bitcnt_q <= '0;
            disp_q   <= '0;
        end else if (bit_valid) begin
            sh_q     <= new_byte[6:0];
            bitcnt_q <= bitcnt_q + 1'b1;
            if (byte_done) disp_q <= {disp_q[23:0], new_byte};
        end
    end

    // FIFO control.
    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wptr_q, rptr_q;
    logic [LVL_W-1:0] level_q;
    logic [15:0]      ovf_q;
    logic [1:0]       state_q, state_d;
    logic             empty, full, pop, push_ok, drop;

    assign empty   = (level_q == '0);
    assign full    = (level_q == LVL_W'(FIFO_DEPTH));
    assign pop     = (state_q == StIdle) && !empty;
    assign push_ok = byte_done && (!full || pop);
    assign drop    = byte_done && full && !pop;

    // FIFO storage; validity is tracked by the pointers, so no reset needed.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wptr_q] <= new_byte;
    end

    // FIFO pointers, level and overflow counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
            ovf_q   <= '0;
        end else begin
            if (push_ok) wptr_q <= wptr_q + 1'b1;
            if (pop)     rptr_q <= rptr_q + 1'b1;
            if (push_ok && !pop)      level_q <= level_q + 1'b1;
            else if (pop && !push_ok) level_q <= level_q - 1'b1;
            if (drop && (ovf_q != 16'hFFFF)) ovf_q <= ovf_q + 1'b1;
        end
    end

    // UART transmitter next-state.
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        tx_q, tx_d;
    logic              baud_end;

    assign baud_end = (baud_q == BAUD_W'(BIT_CYCLES - 1));

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        tx_d    = tx_q;
        case (state_q)
            StIdle: begin
                if (!empty) begin
                    state_d = StStart;
                    tx_d    = mem_q[rptr_q];
                    baud_d  = '0;
                end
            end
            StStart: begin
                if (baud_end) begin
                    state_d = StData;
                    baud_d  = '0;
                    bit_d   = '0;
                end else begin
                    baud_d  = baud_q + 1'b1;
                end
            end
            StData: begin
                if (baud_end) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) state_d = StStop;
                    else               bit_d   = bit_q + 1'b1;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: begin
                if (baud_end) begin
                    state_d = StIdle;
                    baud_d  = '0;
                end else begin
                    baud_d  = baud_q + 1'b1;
                end
            end
        endcase
    end

    // UART state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            baud_q  <= '0;
            bit_q   <= '0;
            tx_q    <= '0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            tx_q    <= tx_d;
        end
    end

    // Serial line level from the current FSM state.
    always_comb begin
        case (state_q)
            StStart: TxD = 1'b0;
            StData:  TxD = tx_q[bit_q];
            default: TxD = 1'b1;
        endcase
    end

    assign disp_word      = disp_q;
    assign health_fail    = fail_q;
    assign fifo_level     = level_q;
    assign overflow_count = ovf_q;

endmodule

// File: tb/tb_hwrandom_stream.sv
// Self-checking bench for hwrandom_stream: directed scenarios with a byte
// scoreboard checked against a UART frame decoder.
module tb_hwrandom_stream;

    localparam int unsigned NCH    = 2;
    localparam int unsigned SDIV   = 2;
    localparam int unsigned FDEPTH = 4;
    localparam int unsigned RLIM   = 32;
    localparam int unsigned CLKF   = 16;
    localparam int unsigned BAUD   = 1;
    localparam int          BITC   = CLKF / BAUD;
    localparam int          LVLW   = $clog2(FDEPTH + 1);

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [NCH-1:0]  raw_bits = '0;
    logic            TxD;
    logic [31:0]     disp_word;
    logic            health_fail;
    logic [LVLW-1:0] fifo_level;
    logic [15:0]     overflow_count;

    always #5 clk = ~clk;

    hwrandom_stream #(
        .NUM_CHANNELS      (NCH),
        .SAMPLE_DIV        (SDIV),
        .FIFO_DEPTH        (FDEPTH),
        .REP_LIMIT         (RLIM),
        .comm_clk_frequency(CLKF),
        .baud_rate         (BAUD)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .raw_bits      (raw_bits),
        .TxD           (TxD),
        .disp_word     (disp_word),
        .health_fail   (health_fail),
        .fifo_level    (fifo_level),
        .overflow_count(overflow_count)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int t = -8;          // negedge index; reset released at t == 0
    int mode = 0;        // 0: AA/5B then hold, 1: byte stream, 2: von Neumann
    int last_push_m = 0;
    logic [7:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] byte_of(input int md, input int k);
        if (md == 0) begin
            if (k == 0) return 8'hAA;
            if (k == 1) return 8'h5B;
            return 8'h00;
        end
        return 8'((k * 61 + 23) % 256);
    endfunction

    // raw_bits value that should become strobe sample m (1-based).
    function automatic logic [1:0] raw_of(input int md, input int m);
        logic [7:0]  b;
        logic [0:19] vn;
        logic        s;
        if (m < 1) return 2'b00;
        if (md == 2) begin
            vn = 20'b0110_0011_1001_1010_0101;
            if (m <= 20) return vn[m-1] ? 2'b01 : 2'b00;
            s = ((((m - 21) / 2) % 2) == 1);
            return s ? 2'b10 : 2'b11;
        end
        if (md == 0 && m > 16) return 2'b11;
        b = byte_of(md, (m - 1) / 8);
        s = b[7 - ((m - 1) % 8)];
        if (!s) return 2'b00;
        return (m % 2 == 1) ? 2'b01 : 2'b10;
    endfunction

    function automatic logic [31:0] exp_disp(input int md, input int nbytes);
        logic [31:0] w = '0;
        for (int k = 0; k < nbytes; k++) w = {w[23:0], byte_of(md, k)};
        return w;
    endfunction

    // One clock of stimulus: sample m is taken at posedge SDIV*m after release,
    // and two synchroniser flops sit in front of it.
    task automatic step();
        int m;
        @(negedge clk);
        t = t + 1;
        if (t == 0) reset = 1'b0;
        m = (t + 3 >= 0) ? (t + 3) / int'(SDIV) : 0;
        raw_bits = raw_of(mode, m);
        if (mode == 0 && m >= 8 && m <= 40 && (m % 8) == 0 && m > last_push_m) begin
            exp_q.push_back(byte_of(0, m / 8 - 1));
            last_push_m = m;
        end
    endtask

    task automatic run_to(input int n);
        while (t < n) step();
    endtask

    task automatic start(input int md);
        mode = md;
        reset = 1'b1;
        last_push_m = 0;
        exp_q.delete();
        t = -8;
        run_to(-1);
        check("rst_txd", 32'(TxD), 32'd1);
        check("rst_disp", disp_word, 32'd0);
        check("rst_health", 32'(health_fail), 32'd0);
        check("rst_level", 32'(fifo_level), 32'd0);
        check("rst_ovf", 32'(overflow_count), 32'd0);
        run_to(0);
    endtask

    // UART decoder: checks each level lasts BITC clocks, framing, byte order
    // and back-to-back spacing.
    int         ncyc = 0;
    bit         mon_en = 1'b0;
    bit         mon_busy = 1'b0;
    int         mon_cnt = 0;
    int         mon_frames = 0;
    int         mon_last_start = 0;
    logic       mon_lvl = 1'b1;
    bit         mon_glitch = 1'b0;
    logic [9:0] mon_frame = '0;
    logic [7:0] expb;

    always @(negedge clk) begin
        ncyc++;
        if (!mon_en) begin
            mon_busy   = 1'b0;
            mon_frames = 0;
        end else if (!mon_busy && TxD === 1'b0) begin
            mon_busy   = 1'b1;
            mon_cnt    = 0;
            mon_glitch = 1'b0;
            if (mon_frames > 0) check("tx_gap", 32'(ncyc - mon_last_start), 32'(10 * BITC + 1));
            mon_last_start = ncyc;
        end
        if (mon_en && mon_busy) begin
            if (mon_cnt % BITC == 0) mon_lvl = TxD;
            else if (TxD !== mon_lvl) mon_glitch = 1'b1;
            mon_frame[mon_cnt / BITC] = mon_lvl;
            if (mon_cnt == 10 * BITC - 1) begin
                mon_busy = 1'b0;
                mon_frames++;
                expb = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
                check("tx_bit_width", 32'(mon_glitch), 32'd0);
                check("tx_framing", 32'({mon_frame[9], mon_frame[0]}), 32'b10);
                check("tx_byte", 32'(mon_frame[8:1]), 32'(expb));
            end
            mon_cnt++;
        end
    end

    initial begin
`ifdef HWRANDOM_VON_NEUMANN_EN
        start(2);
        run_to(16);
        check("vn_no_byte_disp", disp_word, 32'd0);
        check("vn_no_byte_level", 32'(fifo_level), 32'd0);
        run_to(39);
        check("vn_disp_before", disp_word, 32'd0);
        run_to(40);
        check("vn_byte", disp_word, 32'h0000006C);
        check("vn_level", 32'(fifo_level), 32'd1);
`else
        // Alternating bits, then a constant run that trips the health test.
        mon_en = 1'b1;
        start(0);
        run_to(15);
        check("first_byte_early", disp_word, 32'd0);
        run_to(16);
        check("first_byte", disp_word, 32'h000000AA);
        check("first_level", 32'(fifo_level), 32'd1);
        run_to(17);
        check("first_pop", 32'(fifo_level), 32'd0);
        run_to(80);
        check("level_full", 32'(fifo_level), 32'd4);
        run_to(95);
        check("health_before", 32'(health_fail), 32'd0);
        run_to(96);
        check("health_trip", 32'(health_fail), 32'd1);
        run_to(150);
        check("health_level", 32'(fifo_level), 32'd4);
        check("health_disp", disp_word, exp_disp(0, 5));
        check("health_ovf", 32'(overflow_count), 32'd0);
        run_to(830);
        check("tx_frames", 32'(mon_frames), 32'd5);
        check("tx_left", 32'(exp_q.size()), 32'd0);
        check("drained_level", 32'(fifo_level), 32'd0);
        check("health_sticky", 32'(health_fail), 32'd1);
        mon_en = 1'b0;

        // Production outpaces the UART: overflow, then reset mid-DATA.
        start(1);
        run_to(100);
        check("ovf_1", 32'(overflow_count), 32'd1);
        check("ovf_disp_1", disp_word, exp_disp(1, 6));
        check("ovf_level_1", 32'(fifo_level), 32'd4);
        run_to(150);
        check("ovf_4", 32'(overflow_count), 32'd4);
        check("ovf_disp_4", disp_word, exp_disp(1, 9));
        check("ovf_level_4", 32'(fifo_level), 32'd4);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_txd", 32'(TxD), 32'd1);
        check("midrst_level", 32'(fifo_level), 32'd0);
        check("midrst_disp", disp_word, 32'd0);
        check("midrst_ovf", 32'(overflow_count), 32'd0);
        check("midrst_health", 32'(health_fail), 32'd0);

        // Strobe phase after release.
        start(0);
        run_to(15);
        check("rerun_early", disp_word, 32'd0);
        run_to(16);
        check("rerun_byte", disp_word, 32'h000000AA);
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/hwrandom_stream.md
Name: hwrandom_stream

Overview:
- Second-generation entropy pipeline for the hardware RNG.
- Takes NUM_CHANNELS raw ring-oscillator bank outputs and XOR-folds them into one bit per sample.
- Applies a repetition-count health test and optional von Neumann debiasing, assembles bytes, buffers them in a FIFO and streams them over 8N1 UART.
- Sits between the external ring-oscillator banks and the board top level; also drives the 32-bit word for the hex display.

Parameters:
- NUM_CHANNELS, 4: number of raw entropy inputs, 1..32.
- SAMPLE_DIV, 8: clocks per sample strobe, >=1.
- FIFO_DEPTH, 16: byte FIFO entries, power of two, >=2.
- REP_LIMIT, 32: consecutive identical samples that trip the health test, >=2.
- comm_clk_frequency, 50_000_000: clk frequency in Hz.
- baud_rate, 115200: UART bit rate.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- raw_bits  in  NUM_CHANNELS  asynchronous ring-oscillator outputs.
- TxD  out  1  UART 8N1 serial output, idle high.
- disp_word  out  32  last four assembled bytes, newest in [7:0].
- health_fail  out  1  sticky repetition-test failure flag.
- fifo_level  out  $clog2(FIFO_DEPTH+1)  bytes currently buffered.
- overflow_count  out  16  bytes dropped on full FIFO; saturates at 16'hFFFF.

Behaviour:
- Reset values: TxD=1, disp_word=0, health_fail=0, fifo_level=0, overflow_count=0. All internal counters, the FIFO, the shift register, the VN pair state and the UART FSM are cleared.
- Reset mid-frame aborts the UART frame; TxD=1 on the next edge.
- Synchroniser: raw_bits pass through 2 flops per bit; the sampled bit s is the XOR-reduction of the synchronised vector.
- Sample strobe: divider counts 0..SAMPLE_DIV-1 and strobes at count SAMPLE_DIV-1. The first strobe occurs SAMPLE_DIV cycles after reset deasserts.
- Health test (on s, every strobe):
  - rep_cnt=1 on the first sample after reset or on a value change; otherwise rep_cnt increments, saturating at REP_LIMIT.
  - When rep_cnt reaches REP_LIMIT, health_fail is set the cycle after that strobe and stays set until reset.
  - The sample that trips the test is discarded.
  - While health_fail=1, no bits are accepted. The FIFO still drains through the UART.
- Accepted bit: s on each strobe (or the VN output, see Optional Feature).
- Byte assembly:
  - sh <= {sh[6:0], bit}; bit counter 0..7.
  - On the 8th accepted bit the byte {sh[6:0], bit} is pushed to the FIFO and disp_word <= {disp_word[23:0], byte}, both the cycle after the strobe.
  - The bit counter wraps to 0.
- FIFO:
  - Synchronous, FIFO_DEPTH entries; fifo_level updates the cycle after a push or pop.
  - Push with full FIFO and no simultaneous pop: byte dropped, overflow_count+1 (saturating). disp_word still updates.
  - Simultaneous push and pop when full: both succeed, level unchanged.
  - Pop on empty never occurs.
- UART TX:
  - BIT_CYCLES = comm_clk_frequency/baud_rate (integer division).
  - FSM states IDLE, START, DATA, STOP.
  - IDLE: TxD=1. If the FIFO is non-empty, pop into the tx register and enter START on the next edge.
  - START: TxD=0 for BIT_CYCLES.
  - DATA: 8 bits LSB first, each BIT_CYCLES long.
  - STOP: TxD=1 for BIT_CYCLES, then IDLE.
  - With data pending, the gap between one stop bit and the next start bit is exactly 1 clk (the IDLE cycle).

Optional Feature:
- Macro: HWRANDOM_VON_NEUMANN_EN.
- Defined:
  - Each accepted strobe sample fills a pair register (first, second).
  - Pair 01 emits 0; pair 10 emits 1; pairs 00 and 11 emit nothing.
  - The pair state clears after the second sample.
  - Health-test discarded samples do not enter the pair.
  - Throughput is at most one bit per two strobes.
- Undefined: every accepted sample goes directly to byte assembly; no pair logic is synthesised.

Test Plan:
- Test bench parameters, except where a scenario overrides them: NUM_CHANNELS=2, SAMPLE_DIV=2, comm_clk_frequency=16, baud_rate=1 (BIT_CYCLES=16), macro undefined.
- raw_bits alternating 01,00 on each strobe (s=1,0,1,0...) -> first byte 8'hAA pushed; disp_word=32'h000000AA; TxD frame 0,0,1,0,1,0,1,0,1,1, each level 16 cycles.
- Hold raw_bits=2'b11 (s=0) with REP_LIMIT=32 -> health_fail rises the cycle after the 32nd strobe; fifo_level stops increasing; no further bytes pushed.
- Produce bytes faster than UART drain (SAMPLE_DIV=1, FIFO_DEPTH=4) -> fifo_level saturates at 4; overflow_count increments once per dropped byte; disp_word tracks every assembled byte.
- Assert reset mid-DATA of a frame -> TxD=1, fifo_level=0, disp_word=0, health_fail=0 the next cycle; first strobe SAMPLE_DIV cycles after release.
- Macro defined, s sequence 0,1,1,0,0,0,1,1 -> emitted bits 0,1 only; bit counter=2; no byte pushed.
- Two bytes queued back-to-back -> second start bit begins exactly 1 cycle after the first stop bit ends.
